// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO write-side bundle for fifo_wr_arbiter.
// The master modport is the arbiter's view, and the slave modport is the environment's view.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_full;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ write requesters into one FIFO write port.
// Each grant lasts up to MAX_BURST beats; the FIFO's full flag stalls the owner without releasing it.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.master  bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    last_owner_q, last_owner_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic                  pick_found;
  logic [ID_W-1:0]       pick_id;
  logic                  owner_valid;
  logic [DATA_WIDTH-1:0] owner_data;
  logic [NUM_REQ-1:0]    ready_vec;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  busy_int;

  // Round-robin scan: indices above last_owner first, then wrap to the low ones.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && bus.req_valid[i] && (ID_W'(i) > last_owner_q)) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && bus.req_valid[i] && (ID_W'(i) <= last_owner_q)) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(i);
      end
    end
  end

  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == ID_W'(i)) begin
        owner_valid = bus.req_valid[i];
        owner_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= ID_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    ready_vec    = '0;
    wr_en        = 1'b0;
    wr_data      = '0;
    busy_int     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d    = pick_id;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        busy_int = 1'b1;
        // A full FIFO freezes everything; the owner keeps the grant.
        if (!bus.fifo_full) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == ID_W'(i)) ready_vec[i] = 1'b1;
          end
          if (!owner_valid) begin
            state_d      = IDLE;
            last_owner_d = owner_q;
          end else begin
            wr_en      = 1'b1;
            wr_data    = owner_data;
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
              state_d      = IDLE;
              last_owner_d = owner_q;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset masks outputs immediately so an aborted burst never leaks a beat.
  assign bus.req_ready    = rst ? '0 : ready_vec;
  assign bus.fifo_wr_en   = rst ? 1'b0 : wr_en;
  assign bus.fifo_wr_data = rst ? '0 : wr_data;
  assign bus.busy         = rst ? 1'b0 : busy_int;
  assign bus.grant_id     = (rst || !busy_int) ? '0 : owner_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed burst scenarios followed by a long random run,
// every cycle compared against an integer-level round-robin reference model.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 16;
  localparam int MAX_BURST  = 4;
  localparam int DW_ALL     = NUM_REQ * DATA_WIDTH;
  localparam int WAIT_BOUND = (NUM_REQ - 1) * (MAX_BURST + 1) + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: owner is -1 when nobody holds the grant.
  int mOwner = -1;
  int mBeats = 0;
  int mLast  = NUM_REQ - 1;
  int waitCnt [NUM_REQ];
  int accCnt  [NUM_REQ];
  int wrCnt   [NUM_REQ];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkCycle();
    logic [NUM_REQ-1:0]    eReady;
    logic                  eWr;
    logic                  eBusy;
    logic [DATA_WIDTH-1:0] eData;
    int                    eGid;
    bit                    found;
    int                    cand;
    eReady = '0;
    eWr    = 1'b0;
    eBusy  = 1'b0;
    eData  = '0;
    eGid   = 0;
    if (!rst && mOwner >= 0) begin
      eBusy = 1'b1;
      eGid  = mOwner;
      if (!bus.fifo_full) begin
        eReady[mOwner] = 1'b1;
        eWr            = bus.req_valid[mOwner];
      end
      if (eWr) eData = bus.req_data[mOwner*DATA_WIDTH +: DATA_WIDTH];
    end
    checkOutput("busy",    64'(bus.busy),         64'(eBusy));
    checkOutput("grantId", 64'(bus.grant_id),     64'(eGid));
    checkOutput("ready",   64'(bus.req_ready),    64'(eReady));
    checkOutput("wrEn",    64'(bus.fifo_wr_en),   64'(eWr));
    checkOutput("wrData",  64'(bus.fifo_wr_data), 64'(eData));
    checkOutput("noWrOnFull",  64'(bus.fifo_wr_en && bus.fifo_full), 64'(0));
    checkOutput("readyOneHot", 64'($countones(bus.req_ready) <= 1), 64'(1));

    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_ready[i] && bus.req_valid[i]) accCnt[i]++;
      if (rst || !bus.req_valid[i] || (bus.busy && int'(bus.grant_id) == i)) waitCnt[i] = 0;
      else if (!(bus.busy && bus.fifo_full)) waitCnt[i]++;
      checkOutput("waitBound", 64'(waitCnt[i] <= WAIT_BOUND), 64'(1));
    end
    if (bus.fifo_wr_en) wrCnt[int'(bus.grant_id)]++;

    if (rst) begin
      mOwner = -1;
      mBeats = 0;
      mLast  = NUM_REQ - 1;
    end else if (mOwner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = (mLast + k) % NUM_REQ;
        if (!found && bus.req_valid[cand]) begin
          found  = 1'b1;
          mOwner = cand;
          mBeats = 0;
        end
      end
    end else if (!bus.fifo_full) begin
      if (!bus.req_valid[mOwner]) begin
        mLast  = mOwner;
        mOwner = -1;
      end else begin
        mBeats++;
        if (mBeats == MAX_BURST) begin
          mLast  = mOwner;
          mOwner = -1;
        end
      end
    end
  endtask

  // Drives one cycle's inputs after the rising edge, then checks at the falling edge.
  task automatic applyStimulus(input logic r, input logic [NUM_REQ-1:0] v,
                               input logic [DW_ALL-1:0] d, input logic f);
    @(posedge clk);
    #1;
    rst           = r;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.fifo_full = f;
    @(negedge clk);
    checkCycle();
  endtask

  task automatic doReset();
    applyStimulus(1'b1, '0, '0, 1'b0);
    applyStimulus(1'b1, '0, '0, 1'b0);
  endtask

  initial begin
    logic [NUM_REQ-1:0]    v;
    logic [NUM_REQ-1:0]    accPrev;
    logic [DW_ALL-1:0]     d;
    logic [DATA_WIDTH-1:0] w;
    int                    beat;

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      waitCnt[i] = 0;
      accCnt[i]  = 0;
      wrCnt[i]   = 0;
    end

    $display("[TB] reset and full round-robin rotation");
    doReset();
    d = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    for (int c = 0; c < 25; c++) begin
      applyStimulus(1'b0, 4'b1111, d, 1'b0);
      checkOutput("rrBusy", 64'(bus.busy), 64'((c % 5) != 0));
      if ((c % 5) != 0) checkOutput("rrGrant", 64'(bus.grant_id), 64'((c / 5) % 4));
    end

    $display("[TB] requester 2 alone");
    doReset();
    beat = 0;
    for (int c = 0; c < 6; c++) begin
      v = (beat < 4) ? 4'b0100 : 4'b0000;
      w = 16'hA5A0 + 16'(beat);
      d = {16'h0000, w, 32'h0};
      applyStimulus(1'b0, v, d, 1'b0);
      if (c == 0) checkOutput("soloLatency", 64'(bus.busy), 64'(0));
      if (c >= 1 && c <= 4) begin
        checkOutput("soloGid",  64'(bus.grant_id), 64'(2));
        checkOutput("soloWr",   64'(bus.fifo_wr_en), 64'(1));
        checkOutput("soloData", 64'(bus.fifo_wr_data), 64'(16'hA5A0 + 16'(c - 1)));
      end
      if (bus.fifo_wr_en) beat++;
    end
    checkOutput("soloBeats", 64'(beat), 64'(4));

    $display("[TB] full stall mid-burst");
    doReset();
    beat = 0;
    for (int c = 0; c < 9; c++) begin
      v = (beat < 4) ? 4'b0010 : 4'b0000;
      w = 16'h1100 + 16'(beat);
      d = {32'h0, w, 16'h0};
      applyStimulus(1'b0, v, d, (c >= 3 && c <= 5));
      if (c >= 3 && c <= 5) begin
        checkOutput("stallReady", 64'(bus.req_ready[1]), 64'(0));
        checkOutput("stallWr",    64'(bus.fifo_wr_en), 64'(0));
        checkOutput("stallBusy",  64'(bus.busy), 64'(1));
      end
      if (bus.fifo_wr_en) begin
        checkOutput("stallData", 64'(bus.fifo_wr_data), 64'(16'h1100 + 16'(beat)));
        beat++;
      end
    end
    checkOutput("stallBeats", 64'(beat), 64'(4));

    $display("[TB] early release and rescan");
    doReset();
    d = {16'h3003, 16'h2002, 16'h1001, 16'h0000};
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 4'b0010, d, 1'b0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 4'b1000, d, 1'b0);
      if (c > 0) checkOutput("dropGid", 64'(bus.grant_id), 64'(3));
    end
    applyStimulus(1'b0, 4'b0111, d, 1'b0);
    checkOutput("dropNoWrite", 64'(bus.fifo_wr_en), 64'(0));
    applyStimulus(1'b0, 4'b0111, d, 1'b0);
    checkOutput("dropIdle", 64'(bus.busy), 64'(0));
    applyStimulus(1'b0, 4'b0111, d, 1'b0);
    checkOutput("rescanGid", 64'(bus.grant_id), 64'(0));

    $display("[TB] reset mid-burst");
    doReset();
    applyStimulus(1'b0, 4'b0010, d, 1'b0);
    applyStimulus(1'b0, 4'b0010, d, 1'b0);
    applyStimulus(1'b1, 4'b0010, d, 1'b0);
    checkOutput("rstAbortWr", 64'(bus.fifo_wr_en), 64'(0));
    applyStimulus(1'b0, 4'b0110, d, 1'b0);
    checkOutput("postRstBusy",  64'(bus.busy), 64'(0));
    checkOutput("postRstReady", 64'(bus.req_ready), 64'(0));
    checkOutput("postRstData",  64'(bus.fifo_wr_data), 64'(0));
    applyStimulus(1'b0, 4'b0110, d, 1'b0);
    checkOutput("postRstGid", 64'(bus.grant_id), 64'(1));

    $display("[TB] random traffic");
    doReset();
    v       = '0;
    accPrev = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accPrev[i])  v[i] = ($urandom_range(0, 1) == 1);
        else if (v[i])   v[i] = ($urandom_range(0, 15) != 0);
        else             v[i] = ($urandom_range(0, 2) == 0);
        d[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($urandom);
      end
      applyStimulus(($urandom_range(0, 499) == 0), v, d, ($urandom_range(0, 3) == 0));
      accPrev = bus.req_ready & bus.req_valid;
    end
    for (int i = 0; i < NUM_REQ; i++) checkOutput("accVsWr", 64'(accCnt[i]), 64'(wrCnt[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16: write-data width, matching the FIFO's DATA_WIDTH.
REQ-003 The block SHALL have parameter MAX_BURST, default 4: maximum beats per grant (power of 2, 1..16).
REQ-004 The block SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester write request.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*DATA_WIDTH bits: requester i's data at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port req_ready, output, NUM_REQ bits: per-requester accept.
REQ-009 The block SHALL have port fifo_wr_en, output, 1 bit: write strobe to the FIFO.
REQ-010 The block SHALL have port fifo_wr_data, output, DATA_WIDTH bits: write data to the FIFO.
REQ-011 The block SHALL have port fifo_full, input, 1 bit: FIFO full flag, combinational from the FIFO.
REQ-012 The block SHALL have port grant_id, output, $clog2(NUM_REQ) bits: current owner index, valid while busy.
REQ-013 The block SHALL have port busy, output, 1 bit: high in state GRANT.

Function
REQ-014 The block SHALL implement FSM states IDLE and GRANT, plus registers owner, last_owner and beat_cnt ($clog2(MAX_BURST)+1 bits).
REQ-015 In IDLE with any req_valid bit high, the block SHALL select the first set bit scanning last_owner+1, last_owner+2, ... modulo NUM_REQ, latch it into owner, clear beat_cnt, and enter GRANT next cycle.
REQ-016 In IDLE, the block SHALL drive req_ready=0 and fifo_wr_en=0; minimum latency from req_valid to first write SHALL be 1 cycle.
REQ-017 In GRANT, the block SHALL drive req_ready[owner] = !fifo_full and all other req_ready bits = 0, combinationally.
REQ-018 In GRANT, the block SHALL drive fifo_wr_en = req_valid[owner] && !fifo_full and fifo_wr_data = req_data[owner], combinationally.
REQ-019 A beat SHALL be a cycle with fifo_wr_en=1; each beat SHALL increment beat_cnt by 1.
REQ-020 With fifo_full=1, the block SHALL transfer nothing, hold beat_cnt and stay in GRANT (no release on full).
REQ-021 On a beat with beat_cnt==MAX_BURST-1, the block SHALL return to IDLE next cycle with last_owner<=owner.
REQ-022 In GRANT with req_valid[owner]=0 and fifo_full=0, the block SHALL write nothing, return to IDLE next cycle and set last_owner<=owner.
REQ-023 A requester SHALL NOT receive req_ready while another holds the grant; requests arriving mid-grant SHALL wait for IDLE arbitration.
REQ-024 fifo_wr_data SHALL be all zeros when fifo_wr_en=0.
REQ-025 The block SHALL never assert fifo_wr_en while fifo_full=1, and SHALL never assert more than one req_ready bit.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL set state=IDLE, owner=0, beat_cnt=0 and last_owner=NUM_REQ-1, so requester 0 has top priority after reset.
REQ-027 During and after reset, outputs SHALL be: req_ready=0, fifo_wr_en=0, fifo_wr_data=0, busy=0, grant_id=0.
REQ-028 Reset asserted mid-burst SHALL abort the grant in that cycle; the partial burst's unwritten beats SHALL be dropped from the arbiter's view.

Verification
REQ-029 Reset, then req_valid=4'b1111 held, fifo_full=0 -> grants SHALL occur in order 0,1,2,3,0, each with exactly 4 beats on consecutive cycles and one IDLE cycle between grants.
REQ-030 Requester 2 alone, data 0xA5A0..0xA5A3, fifo_full=0 -> busy rises 1 cycle after req_valid; the FIFO SHALL receive 0xA5A0, 0xA5A1, 0xA5A2, 0xA5A3 in 4 consecutive cycles, and grant_id=2 throughout.
REQ-031 Requester 1 granted and fifo_full=1 for 3 cycles after beat 2 -> req_ready[1]=0 and fifo_wr_en=0 for those 3 cycles; beats 3-4 SHALL follow once full drops, with no data loss or duplication.
REQ-032 Requester 3 drops req_valid after 2 beats -> return to IDLE next cycle; next arbitration SHALL start scanning at requester 0.
REQ-033 rst pulsed during beat 2 of a requester-1 burst -> all outputs are 0 on the next cycle; with req_valid=4'b0110 afterwards, requester 1 SHALL be granted first.
REQ-034 Scoreboard with random valid, data and fifo_full over 10k cycles -> REQ-025 SHALL hold every cycle, per-requester FIFO write order SHALL match each requester's accepted order, and no requester SHALL wait more than (NUM_REQ-1)*MAX_BURST beats plus full-stall cycles.
